// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default line constants and
// elaboration-time helpers for the baud divider and counter widths.
package uart_pkg;

  localparam int C_CLK_FRQ_DEF    = 100_000_000;
  localparam int C_BAUD_DEF       = 115200;
  localparam int C_OVERSAMPLE_DEF = 16;

  typedef enum logic [2:0] {
    sIdle   = 3'd0,
    sStart  = 3'd1,
    sData   = 3'd2,
    sParity = 3'd3,
    sStop   = 3'd4,
    sBreak  = 3'd5
  } uart_state_t;

  // Rounded clocks per oversample tick.
  function automatic int calc_div(input int clk_frq, input int baud, input int os);
    return (clk_frq + (baud * os) / 2) / (baud * os);
  endfunction

  // Bits needed for a counter with n distinct values (0..n-1).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one-clock strobe every C_DIV clocks, with a
// synchronous clear so the tick phase can be aligned to a start edge.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int C_DIV = 54
) (
  input  logic clk,
  input  logic rstb,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = cnt_width(C_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_DIV - 1);

  logic [CNT_W-1:0] div_cnt_r;

  // Free-running divider, held at zero while clr is asserted.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt_r <= {CNT_W{1'b0}};
      tick      <= 1'b0;
    end else if (clr) begin
      div_cnt_r <= {CNT_W{1'b0}};
      tick      <= 1'b0;
    end else if (div_cnt_r == CNT_LAST) begin
      div_cnt_r <= {CNT_W{1'b0}};
      tick      <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + 1'b1;
      tick      <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver (LSB-first, start + W data + stop). Defining
// UART_RX_PARITY_EN inserts a parity bit checked per C_PARITY_ODD.
module uart_rx
  import uart_pkg::*;
#(
  parameter int C_CLK_FRQ         = C_CLK_FRQ_DEF,
  parameter int C_BAUD            = C_BAUD_DEF,
  parameter int C_OVERSAMPLE      = C_OVERSAMPLE_DEF,
  parameter int C_UART_DATA_WIDTH = 8,
  parameter int C_PARITY_ODD      = 0
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         rx,
  output logic [C_UART_DATA_WIDTH-1:0] UART_msg,
  output logic                         UART_valid,
  output logic                         UART_err
);

  localparam int W      = C_UART_DATA_WIDTH;
  localparam int C_DIV  = calc_div(C_CLK_FRQ, C_BAUD, C_OVERSAMPLE);
  localparam int TICK_W = cnt_width(C_OVERSAMPLE);
  localparam int BIT_W  = cnt_width(W);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(C_OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(C_OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(W - 1);

  if ((C_OVERSAMPLE < 8) || ((C_OVERSAMPLE % 2) != 0) || (C_PARITY_ODD < 0) || (C_PARITY_ODD > 1)) begin : g_bad_cfg
    $error("uart_rx: C_OVERSAMPLE must be even and >= 8, C_PARITY_ODD must be 0 or 1");
  end

  uart_state_t       state_r;
  logic              rx_meta_r;
  logic              rx_sync_r;
  logic              rx_s;
  logic              tick_s;
  logic              clr_s;
  logic              par_ok_s;
  logic [TICK_W-1:0] tick_cnt_r;
  logic [BIT_W-1:0]  bit_cnt_r;
  logic [W-1:0]      shift_r;

  assign rx_s  = rx_sync_r;
  // Divider stays cleared while idle so the first tick is start-edge aligned.
  assign clr_s = (state_r == sIdle);

`ifdef UART_RX_PARITY_EN
  logic par_err_r;

  // True when data plus received parity bit disagree with the configured sense.
  function automatic logic parity_mismatch(input logic [W-1:0] data, input logic par_bit);
    return ((^data) ^ par_bit) != C_PARITY_ODD[0];
  endfunction

  assign par_ok_s = !par_err_r;
`else
  assign par_ok_s = 1'b1;
`endif

  uart_baud_gen #(.C_DIV(C_DIV)) u_baud_gen (
    .clk  (clk),
    .rstb (rstb),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Two-flop synchroniser for the asynchronous line, reset to idle-high.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Deframing FSM with registered one-clock valid/err pulses.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_r    <= sIdle;
      tick_cnt_r <= {TICK_W{1'b0}};
      bit_cnt_r  <= {BIT_W{1'b0}};
      shift_r    <= {W{1'b0}};
      UART_msg   <= {W{1'b0}};
      UART_valid <= 1'b0;
      UART_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err_r  <= 1'b0;
`endif
    end else begin
      UART_valid <= 1'b0;
      UART_err   <= 1'b0;
      case (state_r)
        sIdle: begin
          tick_cnt_r <= {TICK_W{1'b0}};
          bit_cnt_r  <= {BIT_W{1'b0}};
          if (!rx_s) state_r <= sStart;
        end
        sStart: if (tick_s) begin
          if (tick_cnt_r == HALF_LAST) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            state_r    <= rx_s ? sIdle : sData;
          end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
          end
        end
        sData: if (tick_s) begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            shift_r    <= {rx_s, shift_r[W-1:1]};
            if (bit_cnt_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_r <= sParity;
`else
              state_r <= sStop;
`endif
            end else begin
              bit_cnt_r <= bit_cnt_r + 1'b1;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        sParity: if (tick_s) begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            par_err_r  <= parity_mismatch(shift_r, rx_s);
            state_r    <= sStop;
          end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
          end
        end
`endif
        sStop: if (tick_s) begin
          if (tick_cnt_r == FULL_LAST) begin
            tick_cnt_r <= {TICK_W{1'b0}};
            if (rx_s && par_ok_s) begin
              UART_msg   <= shift_r;
              UART_valid <= 1'b1;
              state_r    <= sIdle;
            end else begin
              UART_err <= 1'b1;
              state_r  <= rx_s ? sIdle : sBreak;
            end
          end else begin
            tick_cnt_r <= tick_cnt_r + 1'b1;
          end
        end
        // A held-low line reports once, then waits for the line to recover.
        sBreak: if (rx_s) state_r <= sIdle;
        default: state_r <= sIdle;
      endcase
    end
  end

endmodule
